// File: rtl/regbank_pkg.sv
// Shared opcode constants and helpers for the register-bank write scheduler.
// The helper decides whether an ALU opcode writes a destination register.
package regbank_pkg;
    localparam int REG_IDX_W = 4;

    localparam logic [3:0] OP_CMP      = 4'b1000;
    localparam logic [3:0] OP_LDR      = 4'b1001;
    localparam logic [3:0] OP_NOP      = 4'b1100;
    localparam logic [3:0] OP_STR_MASK = 4'b1110;
    localparam logic [3:0] OP_STR_VAL  = 4'b1010;
    localparam logic [3:0] OP_NOP_MASK = 4'b1100;
    localparam logic [3:0] OP_NOP_VAL  = 4'b1100;

    // CMP, STR/undef (101x) and NOP/undef (11xx) leave the register bank alone
    function automatic logic writes_dest(input logic [3:0] op);
        return !((op == OP_CMP) ||
                 ((op & OP_STR_MASK) == OP_STR_VAL) ||
                 ((op & OP_NOP_MASK) == OP_NOP_VAL));
    endfunction
endpackage

// File: rtl/regbank_scoreboard.sv
// Pending-load scoreboard: one bit per register, set on load issue, cleared on return.
// Lookups are made from the registered set only.
module regbank_scoreboard
    import regbank_pkg::*;
#(
    parameter int NREGS = 16
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_set_en,
    input  logic [REG_IDX_W-1:0] i_set_idx,
    input  logic                 i_clr_en,
    input  logic [REG_IDX_W-1:0] i_clr_idx,
    input  logic [REG_IDX_W-1:0] i_chk_sel1,
    input  logic [REG_IDX_W-1:0] i_chk_sel2,
    input  logic [REG_IDX_W-1:0] i_issue_idx,
    input  logic [REG_IDX_W-1:0] i_alu_idx,
    output logic [NREGS-1:0]     o_pending,
    output logic                 o_hazard,
    output logic                 o_issue_ready,
    output logic                 o_alu_blocked,
    output logic                 o_clr_hit
);
    logic [NREGS-1:0] r_pending;
    logic [NREGS-1:0] w_set_mask;
    logic [NREGS-1:0] w_clr_mask;

    assign w_set_mask = i_set_en ? (NREGS'(1) << i_set_idx) : '0;
    assign w_clr_mask = i_clr_en ? (NREGS'(1) << i_clr_idx) : '0;

    always_ff @(posedge i_clk) begin
        if (i_reset)
            r_pending <= '0;
        else
            r_pending <= (r_pending & ~w_clr_mask) | w_set_mask;
    end

    assign o_pending     = r_pending;
    assign o_hazard      = r_pending[i_chk_sel1] | r_pending[i_chk_sel2];
    assign o_issue_ready = !r_pending[i_issue_idx];
    assign o_alu_blocked = r_pending[i_alu_idx];
    assign o_clr_hit     = r_pending[i_clr_idx];
endmodule

// File: rtl/regbank_write_scheduler.sv
// Arbitrates the register bank's single write port between ALU writeback and load return,
// with a starvation counter and registered bank-side outputs.
module regbank_write_scheduler
    import regbank_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int NREGS      = 16,
    parameter int STARVE_MAX = 4
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_alu_valid,
    output logic                 o_alu_ready,
    input  logic [3:0]           i_alu_opcode,
    input  logic [REG_IDX_W-1:0] i_alu_dest,
    input  logic [DATA_W-1:0]    i_alu_data,
    input  logic                 i_ld_issue,
    input  logic [REG_IDX_W-1:0] i_ld_issue_dest,
    output logic                 o_ld_issue_ready,
    input  logic                 i_ld_ret_valid,
    output logic                 o_ld_ret_ready,
    input  logic [REG_IDX_W-1:0] i_ld_ret_dest,
    input  logic [DATA_W-1:0]    i_ld_ret_data,
    input  logic [REG_IDX_W-1:0] i_chk_sel1,
    input  logic [REG_IDX_W-1:0] i_chk_sel2,
    output logic                 o_hazard,
    output logic [NREGS-1:0]     o_pending,
    output logic [REG_IDX_W-1:0] o_rb_dest,
    output logic [DATA_W-1:0]    o_rb_data,
    output logic [3:0]           o_rb_opcode,
    output logic                 o_rb_enable,
    output logic                 o_err_unexpected
);
    localparam logic [3:0] W_STARVE_MAX = 4'(STARVE_MAX);

    logic                 w_issue_ready;
    logic                 w_alu_blocked;
    logic                 w_clr_hit;
    logic                 w_alu_wr;
    logic                 w_alu_elig;
    logic                 w_alu_win;
    logic                 w_ld_win;
    logic                 w_issue_fire;
    logic [3:0]           r_starve;
    logic [REG_IDX_W-1:0] r_rb_dest;
    logic [DATA_W-1:0]    r_rb_data;
    logic [3:0]           r_rb_opcode;
    logic                 r_rb_enable;
    logic                 r_err;

    regbank_scoreboard #(.NREGS(NREGS)) u_sb (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_set_en      (w_issue_fire),
        .i_set_idx     (i_ld_issue_dest),
        .i_clr_en      (w_ld_win),
        .i_clr_idx     (i_ld_ret_dest),
        .i_chk_sel1    (i_chk_sel1),
        .i_chk_sel2    (i_chk_sel2),
        .i_issue_idx   (i_ld_issue_dest),
        .i_alu_idx     (i_alu_dest),
        .o_pending     (o_pending),
        .o_hazard      (o_hazard),
        .o_issue_ready (w_issue_ready),
        .o_alu_blocked (w_alu_blocked),
        .o_clr_hit     (w_clr_hit)
    );

    // A writing ALU op is held off while a load still owns its destination (WAW)
    assign w_alu_wr     = i_alu_valid & writes_dest(i_alu_opcode);
    assign w_alu_elig   = w_alu_wr & !w_alu_blocked;
    assign w_alu_win    = w_alu_elig & (!i_ld_ret_valid | (r_starve == W_STARVE_MAX));
    assign w_ld_win     = i_ld_ret_valid & !w_alu_win;
    assign w_issue_fire = i_ld_issue & w_issue_ready;

    assign o_alu_ready      = !writes_dest(i_alu_opcode) | w_alu_win;
    assign o_ld_ret_ready   = w_ld_win;
    assign o_ld_issue_ready = w_issue_ready;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_starve    <= '0;
            r_rb_dest   <= '0;
            r_rb_data   <= '0;
            r_rb_opcode <= OP_NOP;
            r_rb_enable <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            if (!w_alu_wr || w_alu_win)
                r_starve <= '0;
            else if (w_alu_elig && r_starve != W_STARVE_MAX)
                r_starve <= r_starve + 4'd1;

            r_rb_enable <= w_alu_win | w_ld_win;
            if (w_ld_win) begin
                r_rb_dest   <= i_ld_ret_dest;
                r_rb_data   <= i_ld_ret_data;
                r_rb_opcode <= OP_LDR;
            end else if (w_alu_win) begin
                r_rb_dest   <= i_alu_dest;
                r_rb_data   <= i_alu_data;
                r_rb_opcode <= i_alu_opcode;
            end

            if (w_ld_win && !w_clr_hit)
                r_err <= 1'b1;
        end
    end

    assign o_rb_dest        = r_rb_dest;
    assign o_rb_data        = r_rb_data;
    assign o_rb_opcode      = r_rb_opcode;
    assign o_rb_enable      = r_rb_enable;
    assign o_err_unexpected = r_err;
endmodule

// File: tb/tb_regbank_write_scheduler.sv
// Scoreboard bench: a cycle-level reference model predicts handshakes and queues
// expected bank writes; a negedge monitor pops and compares what the DUT drives.
module tb_regbank_write_scheduler;
    localparam int STARVE_MAX = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        alu_valid = 0, ld_issue = 0, ld_ret_valid = 0;
    logic [3:0]  alu_opcode = 0, alu_dest = 0, ld_issue_dest = 0, ld_ret_dest = 0;
    logic [3:0]  chk_sel1 = 0, chk_sel2 = 0;
    logic [31:0] alu_data = 0, ld_ret_data = 0;
    logic        alu_ready, ld_issue_ready, ld_ret_ready, hazard, rb_enable, err_unexpected;
    logic [15:0] pending;
    logic [3:0]  rb_dest, rb_opcode;
    logic [31:0] rb_data;

    regbank_write_scheduler #(.DATA_W(32), .NREGS(16), .STARVE_MAX(STARVE_MAX)) dut (
        .i_clk(clk), .i_reset(reset),
        .i_alu_valid(alu_valid), .o_alu_ready(alu_ready), .i_alu_opcode(alu_opcode),
        .i_alu_dest(alu_dest), .i_alu_data(alu_data),
        .i_ld_issue(ld_issue), .i_ld_issue_dest(ld_issue_dest), .o_ld_issue_ready(ld_issue_ready),
        .i_ld_ret_valid(ld_ret_valid), .o_ld_ret_ready(ld_ret_ready),
        .i_ld_ret_dest(ld_ret_dest), .i_ld_ret_data(ld_ret_data),
        .i_chk_sel1(chk_sel1), .i_chk_sel2(chk_sel2), .o_hazard(hazard), .o_pending(pending),
        .o_rb_dest(rb_dest), .o_rb_data(rb_data), .o_rb_opcode(rb_opcode),
        .o_rb_enable(rb_enable), .o_err_unexpected(err_unexpected)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [3:0]  dest;
        logic [31:0] data;
        logic [3:0]  op;
    } wr_t;

    wr_t  expq[$];
    int   total = 0, bad = 0, cyc = 0;
    logic rst_at_edge;
    bit   mpend[16];
    int   mstarve = 0;
    bit   merr = 0;
    logic got_alu_ready, got_ld_ready;
    logic [3:0]  last_dest = 0, last_op = 4'b1100;
    logic [31:0] last_data = 0;

    always @(posedge clk) begin
        cyc = cyc + 1;
        rst_at_edge = reset;
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Monitor: compares every presented bank write (and the idle hold) against the queue
    initial begin
        forever begin
            @(negedge clk);
            if (rst_at_edge === 1'b1) begin
                expq.delete();
                chk("rst_rb_enable", {63'd0, rb_enable}, 64'd0);
                chk("rst_rb_dest", {60'd0, rb_dest}, 64'd0);
                chk("rst_rb_data", {32'd0, rb_data}, 64'd0);
                chk("rst_rb_opcode", {60'd0, rb_opcode}, 64'hC);
                last_dest = 0; last_data = 0; last_op = 4'b1100;
            end else begin
                while (expq.size() > 0 && expq[0].cyc < cyc) begin
                    chk("missing_write", 64'd0, {32'd0, expq[0].cyc});
                    void'(expq.pop_front());
                end
                if (expq.size() > 0 && expq[0].cyc == cyc) begin
                    wr_t e;
                    e = expq.pop_front();
                    chk("wr_enable", {63'd0, rb_enable}, 64'd1);
                    chk("wr_dest", {60'd0, rb_dest}, {60'd0, e.dest});
                    chk("wr_data", {32'd0, rb_data}, {32'd0, e.data});
                    chk("wr_opcode", {60'd0, rb_opcode}, {60'd0, e.op});
                    last_dest = e.dest; last_data = e.data; last_op = e.op;
                end else begin
                    chk("idle_enable", {63'd0, rb_enable}, 64'd0);
                    chk("hold_rb", {rb_opcode, rb_dest, 24'd0, rb_data}, {last_op, last_dest, 24'd0, last_data});
                end
            end
        end
    end

    function automatic logic [15:0] pend_vec();
        logic [15:0] v;
        for (int i = 0; i < 16; i++) v[i] = mpend[i];
        return v;
    endfunction

    // One cycle: drive, predict from the model, check handshakes, queue the expected write
    task automatic step(input bit av, input logic [3:0] op, input logic [3:0] ad, input logic [31:0] adat,
                        input bit iss, input logic [3:0] idst,
                        input bit rv, input logic [3:0] rdst, input logic [31:0] rdat,
                        input logic [3:0] s1, input logic [3:0] s2);
        bit wr, alu_elig, alu_win, ld_win, iss_ok;
        wr_t e;
        @(negedge clk);
        alu_valid = av; alu_opcode = op; alu_dest = ad; alu_data = adat;
        ld_issue = iss; ld_issue_dest = idst;
        ld_ret_valid = rv; ld_ret_dest = rdst; ld_ret_data = rdat;
        chk_sel1 = s1; chk_sel2 = s2;
        #1;
        wr       = (op < 4'd8) || (op == 4'd9);
        alu_elig = av && wr && !mpend[ad];
        alu_win  = alu_elig && (!rv || mstarve == STARVE_MAX);
        ld_win   = rv && !alu_win;
        iss_ok   = iss && !mpend[idst];
        got_alu_ready = alu_ready;
        got_ld_ready  = ld_ret_ready;
        if (av) chk("alu_ready", {63'd0, alu_ready}, {63'd0, (!wr) || alu_win});
        if (rv) chk("ld_ret_ready", {63'd0, ld_ret_ready}, {63'd0, ld_win});
        chk("ld_issue_ready", {63'd0, ld_issue_ready}, {63'd0, !mpend[idst]});
        chk("hazard", {63'd0, hazard}, {63'd0, mpend[s1] || mpend[s2]});
        chk("pending", {48'd0, pending}, {48'd0, pend_vec()});
        chk("err_unexpected", {63'd0, err_unexpected}, {63'd0, merr});
        if (ld_win) begin
            e.cyc = cyc + 1; e.dest = rdst; e.data = rdat; e.op = 4'b1001;
            expq.push_back(e);
            if (!mpend[rdst]) merr = 1;
            mpend[rdst] = 0;
        end else if (alu_win) begin
            e.cyc = cyc + 1; e.dest = ad; e.data = adat; e.op = op;
            expq.push_back(e);
        end
        if (iss_ok) mpend[idst] = 1;
        if (!(av && wr) || alu_win) mstarve = 0;
        else if (alu_elig && mstarve < STARVE_MAX) mstarve++;
    endtask

    task automatic idle(input logic [3:0] s1);
        step(0, 4'hC, 0, 0, 0, 0, 0, 0, 0, s1, 4'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1; alu_valid = 0; ld_issue = 0; ld_ret_valid = 0;
        @(negedge clk);
        reset = 0;
        for (int i = 0; i < 16; i++) mpend[i] = 0;
        mstarve = 0; merr = 0;
        #1;
        chk("rst_pending", {48'd0, pending}, 64'd0);
        chk("rst_err", {63'd0, err_unexpected}, 64'd0);
    endtask

    initial begin
        int ret_idx;
        int plist[$];
        logic [3:0] rd;
        do_reset();

        // ALU write with no loads outstanding
        step(1, 4'b0010, 4'd3, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0);
        chk("alu_r3_ready", {63'd0, got_alu_ready}, 64'd1);
        idle(0);

        // Load issue/return on r5 with hazard lookups
        step(0, 4'hC, 0, 0, 1, 4'd5, 0, 0, 0, 4'd5, 0);
        idle(4'd5);
        chk("pend_r5", {48'd0, pending}, 64'h0020);
        chk("hazard_r5", {63'd0, hazard}, 64'd1);
        step(0, 4'hC, 0, 0, 0, 0, 1, 4'd5, 32'h1234, 4'd5, 0);
        idle(4'd5);
        chk("hazard_r5_clear", {63'd0, hazard}, 64'd0);

        // WAW: ALU to r5 waits for the load return
        step(0, 4'hC, 0, 0, 1, 4'd5, 0, 0, 0, 0, 0);
        step(1, 4'b0001, 4'd5, 32'hA5A5, 0, 0, 0, 0, 0, 0, 0);
        step(1, 4'b0001, 4'd5, 32'hA5A5, 0, 0, 0, 0, 0, 0, 0);
        step(1, 4'b0001, 4'd5, 32'hA5A5, 0, 0, 1, 4'd5, 32'h5555, 0, 0);
        chk("waw_blocked", {63'd0, got_alu_ready}, 64'd0);
        step(1, 4'b0001, 4'd5, 32'hA5A5, 0, 0, 0, 0, 0, 0, 0);
        chk("waw_released", {63'd0, got_alu_ready}, 64'd1);
        idle(0);

        // Starvation: continuous returns, ALU wins on the fifth contested cycle
        for (int r = 8; r < 14; r++) step(0, 4'hC, 0, 0, 1, 4'(r), 0, 0, 0, 0, 0);
        ret_idx = 8;
        for (int k = 0; k < 6; k++) begin
            step(1, 4'b0011, 4'd1, 32'hC0DE0000 + k, 0, 0, 1, 4'(ret_idx), 32'h100 + ret_idx, 0, 0);
            if (k < 4) chk("starve_lose", {63'd0, got_alu_ready}, 64'd0);
            if (k == 4) chk("starve_win", {63'd0, got_alu_ready}, 64'd1);
            if (got_ld_ready) ret_idx++;
        end
        while (ret_idx < 14) begin
            step(0, 4'hC, 0, 0, 0, 0, 1, 4'(ret_idx), 32'h100 + ret_idx, 0, 0);
            ret_idx++;
        end
        idle(0);

        // Unexpected return, sticky error, then reset
        step(0, 4'hC, 0, 0, 0, 0, 1, 4'd9, 32'h99, 0, 0);
        idle(0);
        idle(0);
        chk("err_sticky", {63'd0, err_unexpected}, 64'd1);
        do_reset();

        // CMP consumed without a write; simultaneous issue r1 / return r2
        step(1, 4'b1000, 4'd7, 32'h77, 0, 0, 0, 0, 0, 0, 0);
        chk("cmp_ready", {63'd0, got_alu_ready}, 64'd1);
        step(0, 4'hC, 0, 0, 1, 4'd2, 0, 0, 0, 0, 0);
        step(0, 4'hC, 0, 0, 1, 4'd1, 1, 4'd2, 32'h22, 0, 0);
        idle(0);
        chk("issue_ret_same_cycle", {48'd0, pending}, 64'h0002);

        // Reset with a load in flight: its late return is flagged
        step(0, 4'hC, 0, 0, 1, 4'd4, 0, 0, 0, 0, 0);
        do_reset();
        step(0, 4'hC, 0, 0, 0, 0, 1, 4'd4, 32'h44, 0, 0);
        idle(0);
        do_reset();

        // Randomised traffic; returns only target outstanding loads
        for (int n = 0; n < 400; n++) begin
            bit rv;
            plist.delete();
            for (int i = 0; i < 16; i++) if (mpend[i]) plist.push_back(i);
            rv = ($urandom_range(0, 1) == 1) && (plist.size() > 0);
            rd = rv ? 4'(plist[$urandom_range(0, plist.size() - 1)]) : 4'd0;
            step($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), $urandom,
                 $urandom_range(0, 2) == 0, 4'($urandom_range(0, 15)),
                 rv, rd, $urandom,
                 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        end
        idle(0);
        idle(0);
        chk("queue_drained", {32'd0, expq.size()}, 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
